imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a 2-entry skid FIFO: the extension is done on accept,
// so each buffered entry already holds the final OUT_W result and its tag.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready is a register so it never sees out_ready.
    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] ext_w;

    always_comb begin
        sext_w = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        case (in_mode)
            2'b00:   ext_w = {{(OUT_W-IN_W){1'b0}}, in_imm};
            2'b01:   ext_w = sext_w;
            2'b10:   ext_w = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: ext_w = {sext_w[OUT_W-3:0], 2'b00};
        endcase
    end

    logic [OUT_W-1:0] data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ_q;
    logic             ready_q;
    logic             push_w;
    logic             pop_w;
    logic [1:0]       occ_next;

    assign out_valid = (occ_q != 2'd0);
    assign push_w    = in_valid && ready_q && !flush;
    assign pop_w     = out_valid && out_ready;

    always_comb begin
        case ({push_w, pop_w})
            2'b10:   occ_next = occ_q + 2'd1;
            2'b01:   occ_next = occ_q - 2'd1;
            default: occ_next = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ_q   <= 2'd0;
            ready_q <= 1'b1;
        end else if (flush) begin
            // Entries are left in place; zero occupancy makes them unreachable.
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ_q   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            if (push_w) begin
                data_q[wr_ptr] <= ext_w;
                tag_q[wr_ptr]  <= in_tag;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_w) begin
                rd_ptr <= ~rd_ptr;
            end
            occ_q   <= occ_next;
            ready_q <= (occ_next != 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = data_q[rd_ptr];
    assign out_tag   = tag_q[rd_ptr];
    assign occupancy = occ_q;

endmodule
